// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state type and op classification helpers for
// the ALU core and its iterative multiply/divide/shift engine.
package alu_pkg;

  localparam logic [7:0] OP_ZERO   = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_AND    = 8'h03;
  localparam logic [7:0] OP_OR     = 8'h04;
  localparam logic [7:0] OP_CLR    = 8'h05;
  localparam logic [7:0] OP_XOR    = 8'h06;
  localparam logic [7:0] OP_LTU    = 8'h07;
  localparam logic [7:0] OP_LT     = 8'h08;
  localparam logic [7:0] OP_SRL    = 8'h09;
  localparam logic [7:0] OP_SRA    = 8'h0a;
  localparam logic [7:0] OP_SL     = 8'h0b;
  localparam logic [7:0] OP_MUL    = 8'h10;
  localparam logic [7:0] OP_MULH   = 8'h11;
  localparam logic [7:0] OP_MULHSU = 8'h12;
  localparam logic [7:0] OP_MULHU  = 8'h13;
  localparam logic [7:0] OP_DIV    = 8'h14;
  localparam logic [7:0] OP_DIVU   = 8'h15;
  localparam logic [7:0] OP_REM    = 8'h16;
  localparam logic [7:0] OP_REMU   = 8'h17;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} alu_state_e;

  function automatic logic is_shift(input logic [7:0] op);
    return op inside {OP_SRL, OP_SRA, OP_SL};
  endfunction

  function automatic logic is_mul(input logic [7:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input logic [7:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Shifts only take the iterative path when the barrel shifter is absent.
  function automatic logic is_multicycle(input logic [7:0] op, input logic fast_shift);
    return is_mul(op) || is_div(op) || (!fast_shift && is_shift(op));
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply, restoring divide and 1-bit
// shifts on operand magnitudes, with sign fix-up folded into the last step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FAST_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic            quick,
  output logic [XLEN-1:0] res
);

  localparam int SW = $clog2(XLEN);

  logic [7:0]      opr;
  logic [XLEN-1:0] hi, lo, opd;
  logic [SW-1:0]   cnt;
  logic            neg_q, neg_r;

  logic            sgn_a, sgn_b, st_sh, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, quick_val;
  logic [SW-1:0]   shamt;
  logic [XLEN:0]   sum, rs, diff;
  logic [XLEN-1:0] nxt_hi, nxt_lo, fix;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    shamt = b[SW-1:0];
    st_sh = (FAST_SHIFT == 0) && is_shift(op);
    sgn_a = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
    sgn_b = (op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
    div0  = is_div(op) && (b == '0);
    ovf   = (op == OP_DIV || op == OP_REM) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    quick = div0 || ovf || (st_sh && shamt == '0);
    quick_val = a;
    if (div0)     quick_val = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
    else if (ovf) quick_val = (op == OP_DIV) ? a : '0;
  end

  // One iteration step on the latched state; the final step also yields the
  // signed, selected result so DONE shows it without an extra cycle.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    rs   = {hi, lo[XLEN-1]};
    diff = rs - {1'b0, opd};
    nxt_hi = hi;
    nxt_lo = lo;
    if (is_mul(opr)) begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], lo[XLEN-1:1]};
    end else if (is_div(opr)) begin
      nxt_hi = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], ~diff[XLEN]};
    end else if (opr == OP_SL) begin
      nxt_lo = {lo[XLEN-2:0], 1'b0};
    end else if (opr == OP_SRA) begin
      nxt_lo = {lo[XLEN-1], lo[XLEN-1:1]};
    end else begin
      nxt_lo = {1'b0, lo[XLEN-1:1]};
    end
    prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    case (opr)
      OP_MUL:                       fix = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix = neg_q ? -nxt_lo : nxt_lo;
      OP_REM, OP_REMU:              fix = neg_r ? -nxt_hi : nxt_hi;
      default:                      fix = nxt_lo;
    endcase
    last = (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opr   <= OP_ZERO;
      hi    <= '0;
      lo    <= '0;
      opd   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else if (start) begin
      opr   <= op;
      hi    <= '0;
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
      cnt   <= st_sh ? shamt - SW'(1) : SW'(XLEN-1);
      if (is_mul(op)) begin
        lo  <= mag_b;
        opd <= mag_a;
      end else if (is_div(op)) begin
        lo  <= mag_a;
        opd <= mag_b;
      end else begin
        lo  <= a;
        opd <= '0;
      end
      if (quick) res <= quick_val;
    end else if (step) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt - SW'(1);
      if (last) res <= fix;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// ALU with combinational single-cycle ops and an IDLE/BUSY/DONE controller
// around the iterative multiply/divide/shift engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FAST_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld,
  input  logic            kill,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] r,
  output logic            bsy,
  output alu_state_e      dbg_state
);

  // Handshake: a request is vld with op/a/b; while bsy=1 the requester holds
  // them stable. The result is taken in the first cycle with vld=1, bsy=0.

  localparam int SW = $clog2(XLEN);

  alu_state_e      state;
  logic            mc, start, step, last, quick;
  logic [XLEN-1:0] comb_r, res;
  logic [SW-1:0]   shamt;

  always_comb begin
    shamt  = b[SW-1:0];
    comb_r = '0;
    case (op)
      OP_ADD: comb_r = a + b;
      OP_SUB: comb_r = a - b;
      OP_AND: comb_r = a & b;
      OP_OR:  comb_r = a | b;
      OP_CLR: comb_r = a & ~b;
      OP_XOR: comb_r = a ^ b;
      OP_LTU: comb_r = {{(XLEN-1){1'b0}}, a < b};
      OP_LT:  comb_r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SRL: if (FAST_SHIFT != 0) comb_r = a >> shamt;
      OP_SRA: if (FAST_SHIFT != 0) comb_r = $unsigned($signed(a) >>> shamt);
      OP_SL:  if (FAST_SHIFT != 0) comb_r = a << shamt;
      default: comb_r = '0;
    endcase
  end

  assign mc        = is_multicycle(op, FAST_SHIFT != 0);
  assign start     = (state == ST_IDLE) && vld && mc && !kill;
  assign step      = (state == ST_BUSY) && !kill;
  assign bsy       = start || step;
  assign r         = (state == ST_DONE && !kill) ? res : comb_r;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (vld && mc) state <= quick ? ST_DONE : ST_BUSY;
        ST_BUSY: if (last) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN), .FAST_SHIFT(FAST_SHIFT)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .op    (op),
    .a     (a),
    .b     (b),
    .last  (last),
    .quick (quick),
    .res   (res)
  );

endmodule
